// File: rtl/count_sample_uart_tx_pkg.sv
// Shared constants, FSM state type and sample-byte packing for the
// counter-sample UART transmitter.
`timescale 1ns/1ps
package count_sample_uart_tx_pkg;

    localparam int         COUNT_W        = 3;
    localparam logic [2:0] TAG            = 3'b101;
    localparam int         BITS_PER_FRAME = 10;
    localparam int         DATA_BITS      = BITS_PER_FRAME - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Byte layout on the wire: tag, miss flag, reserved zero, counter value.
    function automatic logic [7:0] make_sample(input logic miss,
                                               input logic [COUNT_W-1:0] cnt);
        return {TAG, miss, 1'b0, cnt};
    endfunction

endpackage

// File: rtl/count_sample_uart_tx_if.sv
// Counter bus as seen by downstream consumers: enable, value and the
// pin-level sample request.
`timescale 1ns/1ps
interface count_sample_uart_tx_if;
    import count_sample_uart_tx_pkg::*;

    logic               count_en;
    logic [COUNT_W-1:0] count_in;
    logic               sample_req;

    modport master (output count_en, output count_in, output sample_req);
    modport slave  (input  count_en, input  count_in, input  sample_req);

endinterface

// File: rtl/count_sample_uart_tx_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and registered flags.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_PTR = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [AW:0]      w_wr_nxt;
    logic [AW:0]      w_rd_nxt;
    logic [AW:0]      w_used_nxt;
    logic             r_full;
    logic             r_empty;

    // Next pointers and the occupancy they imply; pointers wrap naturally.
    always_comb begin
        w_wr_nxt   = i_push ? (r_wr + PTR_ONE) : r_wr;
        w_rd_nxt   = i_pop  ? (r_rd + PTR_ONE) : r_rd;
        w_used_nxt = w_wr_nxt - w_rd_nxt;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_full  <= (w_used_nxt == DEPTH_PTR);
            r_empty <= (w_used_nxt == '0);
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/count_sample_uart_tx.sv
// Captures tagged counter samples on sample_req rising edges, buffers them
// and sends each one as an 8N1 frame on a single idle-high pin.
`timescale 1ns/1ps
module count_sample_uart_tx
    import count_sample_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    count_sample_uart_tx_if.slave   bus,
    output logic                    o_tx_out,
    output logic                    o_tx_busy,
    output logic                    o_fifo_full,
    output logic                    o_fifo_empty,
    output logic                    o_drop_sticky
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_d;
    logic [1:0]        r_prime;
    logic              r_req_pulse;
    logic              r_miss;
    logic              r_drop;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_dout;

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [BIT_W-1:0]  r_bit;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx_out;
    logic              w_tx_nxt;
    logic              r_busy;

    // Pin synchronizer and rising-edge detector. The edge history holds high
    // until the chain has flushed, so a pin already high at reset release
    // is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_d    <= 1'b1;
            r_prime     <= 2'd0;
            r_req_pulse <= 1'b0;
        end else begin
            r_sync1     <= bus.sample_req;
            r_sync2     <= r_sync1;
            r_prime     <= (r_prime == 2'd2) ? 2'd2 : (r_prime + 2'd1);
            r_sync_d    <= (r_prime == 2'd2) ? r_sync2 : 1'b1;
            r_req_pulse <= r_sync2 & ~r_sync_d;
        end
    end

    // A full FIFO still accepts when the transmitter pops in the same cycle.
    assign w_push = r_req_pulse & bus.count_en & (~w_full | w_pop);

    // Miss flag for the next accepted sample and the sticky drop indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss <= 1'b0;
            r_drop <= 1'b0;
        end else if (r_req_pulse) begin
            if (w_push) begin
                r_miss <= 1'b0;
            end else begin
                r_miss <= 1'b1;
                r_drop <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (make_sample(r_miss, bus.count_in)),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // TX FSM next-state logic; the line level is computed from the next
    // state so the pin itself comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + {{(BIT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_baud_nxt = r_baud + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            STOP: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_baud_nxt = r_baud + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase

        case (w_state_nxt)
            IDLE:    w_tx_nxt = 1'b1;
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            STOP:    w_tx_nxt = 1'b1;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // TX FSM state, counters and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_tx_out <= w_tx_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign o_tx_out      = r_tx_out;
    assign o_tx_busy     = r_busy;
    assign o_fifo_full   = w_full;
    assign o_fifo_empty  = w_empty;
    assign o_drop_sticky = r_drop;

endmodule

// File: tb/tb_count_sample_uart_tx.sv
// Scoreboard bench: expected bytes are queued when a request is issued and
// checked against frames decoded from the serial pin.
`timescale 1ns/1ps
module tb_count_sample_uart_tx;
    import count_sample_uart_tx_pkg::*;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, full, empty, drop;

    always #5 clk = ~clk;

    count_sample_uart_tx_if bus ();

    count_sample_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_tx_out      (tx),
        .o_tx_busy     (busy),
        .o_fifo_full   (full),
        .o_fifo_empty  (empty),
        .o_drop_sticky (drop)
    );

    int         n_vec     = 0;
    int         n_err     = 0;
    int         frames_rx = 0;
    bit         mon_en    = 1'b0;
    bit         mon_busy  = 1'b0;
    logic [7:0] sb_q [$];

    // Frame decoder: samples each bit in its middle and checks against the queue.
    initial begin
        logic [9:0] got;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_en && tx === 1'b0) begin
                mon_busy = 1'b1;
                repeat (CPB/2 - 1) @(negedge clk);
                got[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = tx;
                end
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL frame: unexpected frame bits %b, nothing expected", got);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (got !== {1'b1, exp_b, 1'b0}) begin
                        n_err++;
                        $display("FAIL frame: got start/data/stop %b, expected %b",
                                 got, {1'b1, exp_b, 1'b0});
                    end
                end
                frames_rx++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.sample_req = 1'b0;
        bus.count_en   = 1'b0;
        bus.count_in   = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_req(input logic en, input logic [2:0] cnt);
        bus.count_en   = en;
        bus.count_in   = cnt;
        bus.sample_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.sample_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_busy && busy === 1'b0 && empty === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit low_seen = 1'b0;
        bus.sample_req = 1'b0;
        bus.count_en   = 1'b0;
        bus.count_in   = 3'd0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx, busy, full, empty, drop} !== 5'b10010) begin
            n_err++;
            $display("FAIL reset_state: {tx,busy,full,empty,drop}=%b, expected 10010",
                     {tx, busy, full, empty, drop});
        end
        rst_n = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        n_vec++;
        if (low_seen || empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: low_seen=%0b empty=%b, expected 0 and 1", low_seen, empty);
        end
    endtask

    task automatic test_single();
        int lat = 0;
        int w   = 1;
        bit to;
        int f0;
        apply_reset();
        mon_en = 1'b1;
        f0     = frames_rx;
        sb_q.push_back(8'hA5);
        bus.count_en   = 1'b1;
        bus.count_in   = 3'd5;
        bus.sample_req = 1'b1;
        while (tx !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) bus.sample_req = 1'b0;
        end
        n_vec++;
        if (lat != 5 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: start after %0d cycles busy=%b, expected 5 and 1", lat, busy);
        end
        while (w < 40) begin
            @(negedge clk);
            if (tx !== 1'b0) break;
            w++;
        end
        n_vec++;
        if (w != CPB) begin
            n_err++;
            $display("FAIL single_bit_width: start bit %0d cycles, expected %0d", w, CPB);
        end
        wait_idle(400, to);
        n_vec++;
        if (to || frames_rx - f0 != 1) begin
            n_err++;
            $display("FAIL single_done: timeout=%0b frames=%0d, expected 0 and 1", to, frames_rx - f0);
        end
    endtask

    task automatic test_disabled();
        bit to;
        int f0;
        apply_reset();
        mon_en = 1'b1;
        f0     = frames_rx;
        pulse_req(1'b0, 3'd7);
        repeat (10) @(negedge clk);
        n_vec++;
        if ({drop, empty, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL disabled_drop: {drop,empty,busy}=%b, expected 110", {drop, empty, busy});
        end
        sb_q.push_back(8'hB2);
        pulse_req(1'b1, 3'd2);
        wait_idle(400, to);
        n_vec++;
        if (to || frames_rx - f0 != 1 || drop !== 1'b1) begin
            n_err++;
            $display("FAIL disabled_frames: timeout=%0b frames=%0d drop=%b, expected 0 1 1",
                     to, frames_rx - f0, drop);
        end
    endtask

    task automatic test_overflow();
        bit to;
        bit full_seen = 1'b0;
        int f0;
        int c = 0;
        apply_reset();
        mon_en = 1'b1;
        f0     = frames_rx;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb_q.push_back(8'hA0 | 8'(i));
            pulse_req(1'b1, 3'(i));
            if (full === 1'b1) full_seen = 1'b1;
            repeat (2) @(negedge clk);
            if (full === 1'b1) full_seen = 1'b1;
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if (!full_seen || drop !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_drop: full_seen=%0b drop=%b, expected 1 and 1", full_seen, drop);
        end
        while (full === 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        sb_q.push_back(8'hB6);
        pulse_req(1'b1, 3'd6);
        wait_idle(2000, to);
        n_vec++;
        if (to || frames_rx - f0 != 6) begin
            n_err++;
            $display("FAIL overflow_frames: timeout=%0b frames=%0d, expected 0 and 6", to, frames_rx - f0);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int f0;
        apply_reset();
        mon_en = 1'b1;
        f0     = frames_rx;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(8'hA0 | 8'(i));
            pulse_req(1'b1, 3'(i));
            repeat (2) @(negedge clk);
        end
        repeat (162 - 20) @(negedge clk);
        sb_q.push_back(8'hA5);
        pulse_req(1'b1, 3'd5);
        @(negedge clk);
        n_vec++;
        if ({busy, full, drop} !== 3'b010) begin
            n_err++;
            $display("FAIL simul_idle_gap: {busy,full,drop}=%b, expected 010", {busy, full, drop});
        end
        @(negedge clk);
        n_vec++;
        if ({busy, full, drop} !== 3'b110) begin
            n_err++;
            $display("FAIL simul_push_pop: {busy,full,drop}=%b, expected 110", {busy, full, drop});
        end
        wait_idle(2000, to);
        n_vec++;
        if (to || frames_rx - f0 != 6 || drop !== 1'b0) begin
            n_err++;
            $display("FAIL simul_frames: timeout=%0b frames=%0d drop=%b, expected 0 6 0",
                     to, frames_rx - f0, drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit low_seen = 1'b0;
        apply_reset();
        mon_en = 1'b0;
        pulse_req(1'b1, 3'd5);
        repeat (75 - 2) @(negedge clk);
        n_vec++;
        if ({tx, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_bit3: {tx,busy}=%b, expected 01", {tx, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL mid_async: {tx,busy}=%b, expected 10", {tx, busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        n_vec++;
        if (low_seen || empty !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after: low_seen=%0b empty=%b busy=%b, expected 0 1 0",
                     low_seen, empty, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_disabled();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left: %0d bytes outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
